// File: rtl/shift_issue_stage.sv
// shift_issue_stage
// Issue stage in front of the shifter. It decodes the RV32I shift instructions
// SLL/SRL/SRA and SLLI/SRLI/SRAI, and picks the shift amount from rs2 or from
// the immediate. The result is held in an output register (main) with a
// one-entry skid register behind it, and uses a valid/ready handshake.
// Because in_ready is registered, upstream never sees a combinational path
// from out_ready.
module shift_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] num_shift,
  output logic [4:0]      shift_amount,
  output logic [1:0]      shift_op,
  output logic [RD_W-1:0] rd_out,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRX     = 3'b101;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_NOP = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      amt;
    shift_op_e       op;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } entry_t;

  entry_t dec_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire;

  // The rd field, the rs1 field and the upper rs2 bits do not affect the decode.
  logic unused_bits;
  assign unused_bits = ^{instr[19:15], instr[11:7], rs2_data[XLEN-1:5]};

  assign in_fire = in_valid && in_ready_q;

  // Decode the incoming word into a shifter entry.
  // Any encoding that is not a shift still produces an entry, marked illegal.
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] amt_src;
    opcode  = instr[6:0];
    funct3  = instr[14:12];
    funct7  = instr[31:25];
    amt_src = (opcode == OPC_OP) ? rs2_data[4:0] : instr[24:20];

    dec_entry         = '0;
    dec_entry.data    = rs1_data;
    dec_entry.rd      = rd_in;
    dec_entry.op      = OP_NOP;
    dec_entry.illegal = 1'b1;

    if (opcode == OPC_OP_IMM || opcode == OPC_OP) begin
      if (funct3 == F3_SLL && funct7 == F7_ZERO) begin
        dec_entry.op      = OP_SLL;
        dec_entry.amt     = amt_src;
        dec_entry.illegal = 1'b0;
      end else if (funct3 == F3_SRX && funct7 == F7_ZERO) begin
        dec_entry.op      = OP_SRL;
        dec_entry.amt     = amt_src;
        dec_entry.illegal = 1'b0;
      end else if (funct3 == F3_SRX && funct7 == F7_ALT) begin
        dec_entry.op      = OP_SRA;
        dec_entry.amt     = amt_src;
        dec_entry.illegal = 1'b0;
      end
    end
  end

  // Next-state logic for the main/skid pair.
  // Skid contents always move to main before any new input, which keeps entries in FIFO order.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d      = skid_q;
        out_valid_d = 1'b1;
        if (in_fire) begin
          skid_d       = dec_entry;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        main_d      = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  // Control and output registers, with synchronous reset.
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples its value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      main_q.op    <= OP_NOP;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
    end
  end

  // Skid payload register.
  // NOTE: this register has no reset. It is only read while skid_valid_q is
  // set, and skid_valid_q is reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign num_shift    = main_q.data;
  assign shift_amount = main_q.amt;
  assign shift_op     = main_q.op;
  assign rd_out       = main_q.rd;
  assign illegal      = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage
// Directed bench for shift_issue_stage. It applies a decode vector table, then
// covers backpressure, flush, reset in the middle of a transfer, and a
// randomised back-to-back stream.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num_shift;
  logic [4:0]  shift_amount;
  logic [1:0]  shift_op;
  logic [4:0]  rd_out;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rd_in        (rd_in),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .num_shift    (num_shift),
    .shift_amount (shift_amount),
    .shift_op     (shift_op),
    .rd_out       (rd_out),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic        ill;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] op, input logic [4:0] amt,
                           input logic [31:0] num, input logic [4:0] rd, input logic ill);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_op"},    64'(shift_op), 64'(op));
    check({name, "_amt"},   64'(shift_amount), 64'(amt));
    check({name, "_num"},   64'(num_shift), 64'(num));
    check({name, "_rd"},    64'(rd_out), 64'(rd));
    check({name, "_ill"},   64'(illegal), 64'(ill));
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1;
    instr    = v.instr;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    rd_in    = v.rd;
  endtask

  // srl x5,x6,x7 with a distinct data value and amount per item k.
  task automatic drive_srl(input int k);
    in_valid = 1'b1;
    instr    = 32'h0073_52B3;
    rs1_data = 32'hA000_0000 + k;
    rs2_data = 32'hFFFF_FFE0 | 32'(k + 1);
    rd_in    = 5'(k);
  endtask

  task automatic check_srl(input string name, input int k);
    check_out(name, 2'b00, 5'(k + 1), 32'hA000_0000 + k, 5'(k), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] st_instr [16];
    logic [31:0] st_rs1   [16];
    logic [31:0] st_rs2   [16];
    logic [4:0]  st_rd    [16];
    logic [1:0]  st_op    [16];
    logic [4:0]  st_amt   [16];

    //            instr          rs1            rs2            rd     op     amt     ill
    vecs[0]  = '{32'h4040_D093, 32'hF000_0000, 32'h0000_0000, 5'd1,  2'b10, 5'd4,  1'b0}; // srai x1,x1,4
    vecs[1]  = '{32'h0020_90B3, 32'h1234_5678, 32'h0000_0025, 5'd1,  2'b01, 5'd5,  1'b0}; // sll, upper rs2 bits ignored
    vecs[2]  = '{32'h0220_9093, 32'hDEAD_BEEF, 32'h0000_0003, 5'd1,  2'b11, 5'd0,  1'b1}; // slli with instr[25]=1
    vecs[3]  = '{32'h01F0_9093, 32'h0000_0001, 32'h0000_0007, 5'd1,  2'b01, 5'd31, 1'b0}; // slli x1,x1,31
    vecs[4]  = '{32'h0001_D113, 32'h8765_4321, 32'hFFFF_FFFF, 5'd2,  2'b00, 5'd0,  1'b0}; // srli x2,x3,0
    vecs[5]  = '{32'h0073_52B3, 32'h5555_AAAA, 32'hFFFF_FFFF, 5'd5,  2'b00, 5'd31, 1'b0}; // srl x5,x6,x7
    vecs[6]  = '{32'h4073_52B3, 32'h8000_0000, 32'h0000_0040, 5'd5,  2'b10, 5'd0,  1'b0}; // sra, rs2=64 -> 0
    vecs[7]  = '{32'h0031_00B3, 32'h0000_00FF, 32'h0000_0003, 5'd1,  2'b11, 5'd0,  1'b1}; // add
    vecs[8]  = '{32'h4000_1033, 32'h0F0F_0F0F, 32'h0000_0001, 5'd0,  2'b11, 5'd0,  1'b1}; // sll with funct7=0100000
    vecs[9]  = '{32'h0000_2003, 32'hCAFE_F00D, 32'h0000_0009, 5'd31, 2'b11, 5'd0,  1'b1}; // load
    vecs[10] = '{32'h4210_5013, 32'h7777_7777, 32'h0000_0000, 5'd3,  2'b11, 5'd0,  1'b1}; // srai with funct7=0100001
    vecs[11] = '{32'h41F0_5013, 32'hFFFF_0000, 32'h0000_0002, 5'd30, 2'b10, 5'd31, 1'b0}; // srai 31

    rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state.
    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op", 64'(shift_op), 64'd3);
    check("rst_num", 64'(num_shift), 64'd0);
    check("rst_amt", 64'(shift_amount), 64'd0);
    check("rst_rd", 64'(rd_out), 64'd0);
    check("rst_ill", 64'(illegal), 64'd0);
    rst = 1'b0;

    // Decode table, applied back to back with out_ready held high.
    out_ready = 1'b1;
    for (int c = 0; c <= NV; c++) begin
      if (c < NV) drive_vec(vecs[c]);
      else in_valid = 1'b0;
      tick();
      if (c < NV) begin
        check_out($sformatf("vec%0d", c), vecs[c].op, vecs[c].amt, vecs[c].rs1,
                  vecs[c].rd, vecs[c].ill);
        check($sformatf("vec%0d_in_ready", c), 64'(in_ready), 64'd1);
      end
    end
    check("vec_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: item 0 is held in main, item 1 goes to skid, and in_ready then drops.
    out_ready = 1'b0;
    drive_srl(0);
    tick();
    check_srl("bp_a0", 0);
    check("bp_a0_in_ready", 64'(in_ready), 64'd1);
    drive_srl(1);
    tick();
    check_srl("bp_b0", 0);
    check("bp_b_in_ready", 64'(in_ready), 64'd0);
    drive_srl(2);
    tick();
    check_srl("bp_c0", 0);
    check("bp_c_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check_srl("bp_d1", 1);
    check("bp_d_in_ready", 64'(in_ready), 64'd1);
    tick();
    check_srl("bp_e2", 2);
    drive_srl(3);
    tick();
    check_srl("bp_f3", 3);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid", 64'(out_valid), 64'd0);

    // Flush with main and skid both full, and in_valid asserted.
    out_ready = 1'b0;
    drive_srl(5);
    tick();
    drive_srl(6);
    tick();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive_srl(7);
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_after%0d_valid", i), 64'(out_valid), 64'd0);
    end

    // Flush in the same cycle as an accepted input: the input is dropped.
    out_ready = 1'b0;
    drive_srl(8);
    tick();
    flush = 1'b1;
    drive_srl(9);
    tick();
    check("fl2_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl2_after_valid", 64'(out_valid), 64'd0);
    check("fl2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive_srl(10);
    tick();
    check_srl("fl2_recover", 10);
    in_valid = 1'b0;
    tick();

    // Reset for two cycles while the stage is full and a transfer is in flight.
    out_ready = 1'b0;
    drive_srl(11);
    tick();
    drive_srl(12);
    tick();
    rst = 1'b1;
    drive_srl(13);
    repeat (2) tick();
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_op", 64'(shift_op), 64'd3);
    check("rst2_num", 64'(num_shift), 64'd0);
    check("rst2_amt", 64'(shift_amount), 64'd0);
    check("rst2_rd", 64'(rd_out), 64'd0);
    check("rst2_ill", 64'(illegal), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("rst2_after_valid", 64'(out_valid), 64'd0);

    // Stream 16 random legal shifts back to back. Expected fields come from the
    // generation choices, not from decoding the instruction word.
    for (int i = 0; i < 16; i++) begin
      int          kind;
      logic        use_reg;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  amt;
      logic [4:0]  rs1f;
      logic [4:0]  rs2f;
      logic [4:0]  rdf;
      logic [31:0] r;
      kind    = $urandom_range(0, 2);
      use_reg = 1'($urandom_range(0, 1));
      amt     = 5'($urandom_range(0, 31));
      rs1f    = 5'($urandom_range(0, 31));
      rs2f    = 5'($urandom_range(0, 31));
      rdf     = 5'($urandom_range(0, 31));
      f7      = (kind == 2) ? 7'b0100000 : 7'b0000000;
      f3      = (kind == 1) ? 3'b001 : 3'b101;
      st_op[i]  = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
      st_amt[i] = amt;
      st_rs1[i] = $urandom;
      st_rd[i]  = 5'($urandom_range(0, 31));
      r = $urandom;
      if (use_reg) begin
        st_instr[i] = {f7, rs2f, rs1f, f3, rdf, 7'b0110011};
        st_rs2[i]   = {r[31:5], amt};
      end else begin
        st_instr[i] = {f7, amt, rs1f, f3, rdf, 7'b0010011};
        st_rs2[i]   = r;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        instr    = st_instr[c];
        rs1_data = st_rs1[c];
        rs2_data = st_rs2[c];
        rd_in    = st_rd[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c < 16)
        check_out($sformatf("st%0d", c), st_op[c], st_amt[c], st_rs1[c], st_rd[c], 1'b0);
    end
    check("st_drain_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-issue pipeline stage sitting directly upstream of the shifter.
- Decodes RV32I shift instructions (SLL/SRL/SRA and SLLI/SRLI/SRAI) and selects the shift amount from rs2 or the immediate.
- Registers the operand, amount and op-code for the shifter behind a 2-entry skid buffer with valid/ready handshake, plus flush.
- Its outputs drive the shifter's num_shift, shift_amount and shift_op inputs combinationally.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready.
- instr  input  32  raw instruction word.
- rs1_data  input  32  value to shift.
- rs2_data  input  32  register shift source; only bits [4:0] are used.
- rd_in  input  RD_W  destination register.
- flush  input  1  kill all held entries; takes priority over everything else.
- out_valid  output  1  num_shift/shift_amount/shift_op/rd_out/illegal are valid.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready.
- num_shift  output  32  registered rs1_data.
- shift_amount  output  5  registered shift amount.
- shift_op  output  2  00 SRL, 01 SLL, 10 SRA, 11 no-op.
- rd_out  output  RD_W  registered destination.
- illegal  output  1  entry was not a legal shift encoding.

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high (rst); polarity and synchronicity are fixed. No asynchronous logic.
- Reset, applied at a clk edge while rst=1:
  - out_valid=0, in_ready=1, skid_valid=0.
  - num_shift=0, shift_amount=0, shift_op=2'b11, rd_out=0, illegal=0.
  - Reset mid-transfer discards both entries; no partial state survives.

Decode is combinational on the inputs and captured into a register:
- OP-IMM (opcode 0010011):
  - funct3=001 with instr[31:25]=0000000 -> SLL (01).
  - funct3=101 with instr[31:25]=0000000 -> SRL (00).
  - funct3=101 with instr[31:25]=0100000 -> SRA (10).
  - Amount is instr[24:20].
- OP (opcode 0110011): same funct3/funct7 mapping; amount is rs2_data[4:0].
- Anything else, including SLLI with instr[25]=1, any other funct7, or a non-shift opcode:
  - shift_op=11, shift_amount=0, illegal=1.
  - The entry still flows through the pipeline (the trap is handled downstream).

Storage is an output register (main) plus one skid register. Each clk edge, with rst=0:
- flush=1: out_valid<=0, skid_valid<=0, in_ready<=1. A concurrent input transfer is dropped.
- Main is empty or out_ready=1 (main drains or is empty):
  - If skid_valid: main<=skid.
  - Otherwise, if an input transfer occurs: main<=decoded input.
  - Otherwise: out_valid<=0.
  - If skid_valid and an input transfer occurs in the same cycle, the input goes to skid.
- Main is full and out_ready=0:
  - An input transfer goes to skid, and in_ready<=0 next cycle.
- in_ready is a registered signal equal to !skid_valid. It must never combinationally depend on out_ready.
- Throughput and ordering:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 per cycle when out_ready=1.
  - Strict FIFO order; no entry is duplicated or lost.
- Output stability: while out_valid=1 and out_ready=0, all output fields hold stable.
- Field capture:
  - num_shift captures rs1_data unmodified.
  - shift_amount is always 5 bits.
  - The upper rs2_data bits are ignored, so rs2_data=32'h0000_0025 yields an amount of 5.

Test Plan:
- Reset: assert rst for 2 cycles during an active transfer -> out_valid=0, in_ready=1, shift_op=11, all data outputs 0.
- SRAI: instr=32'h4040_D093 (srai x1,x1,4), rs1_data=32'hF000_0000, out_ready=1 -> next cycle out_valid=1, shift_op=10, shift_amount=4, num_shift=F000_0000, illegal=0.
- SLL register form: instr=32'h0020_90B3 (sll x1,x1,x2), rs2_data=32'h0000_0025 -> shift_amount=5, shift_op=01. Then instr=32'h0220_9093 (SLLI with instr[25]=1) -> illegal=1, shift_op=11.
- Backpressure: stream 4 SRL instructions with out_ready=0 -> first held in main, second in skid, in_ready=0 from the 3rd cycle. Then set out_ready=1 -> all 4 emerge in order with no gaps or duplicates.
- Flush: main and skid full, in_valid=1, flush=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the flushed entries never appear.
- Streaming: 16 back-to-back random shifts with out_ready=1 -> 16 outputs on 16 consecutive cycles. A scoreboard checks op, amount and data against the decode rules.
